scratchpad_bank_param: RTL and testbench

Parametrised scratchpad bank for the tensor-core datapath. It holds MATS matrices of ROWS rows × ROW_W bits, accepts row writes from load/GEMM-result producers and row reads on independent queued interfaces, and routes read data to NCH output channels (channel 0 = DRAM store path, 1..NCH-1 = GEMM operand paths). Beyond the fixed 4×4 bank it adds per-mat written-row tracking with clear, read-after-write hazard stalling, and multi-channel read routing with error reporting.

---
 rtl/scratchpad_bank_param.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_scratchpad_bank_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_bank_param.sv
// Parametrised scratchpad bank: queued row writes, hazard-checked queued reads routed to
// per-channel output FIFOs, per-mat written-row tracking with clear.
module scratchpad_bank_param #(
    parameter int unsigned MATS     = 4,
    parameter int unsigned ROWS     = 4,
    parameter int unsigned ROW_W    = 64,
    parameter int unsigned TAG_W    = 32,
    parameter int unsigned NCH      = 2,
    parameter int unsigned WQ_DEPTH = 2,
    parameter int unsigned RQ_DEPTH = 2,
    parameter int unsigned OQ_DEPTH = 8,
    localparam int unsigned MW = (MATS > 1) ? $clog2(MATS) : 1,
    localparam int unsigned RW = $clog2(ROWS),
    localparam int unsigned CW = $clog2(NCH)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [MW-1:0]          w_mat,
    input  logic [RW-1:0]          w_row,
    input  logic [ROW_W-1:0]       w_data,
    input  logic                   w_gemm,
    input  logic                   r_valid,
    output logic                   r_ready,
    input  logic [MW-1:0]          r_mat,
    input  logic [RW-1:0]          r_row,
    input  logic [CW-1:0]          r_dest,
    input  logic [TAG_W-1:0]       r_tag,
    output logic [NCH-1:0]         o_valid,
    input  logic [NCH-1:0]         o_ren,
    output logic [NCH*MW-1:0]      o_mat,
    output logic [NCH*RW-1:0]      o_row,
    output logic [NCH*TAG_W-1:0]   o_tag,
    output logic [NCH*ROW_W-1:0]   o_data,
    input  logic [MATS-1:0]        mat_clear,
    output logic [MATS-1:0]        mat_full,
    output logic                   load_complete,
    output logic                   gemm_complete,
    output logic [MW-1:0]          complete_mat,
    output logic                   err
);

    localparam int unsigned WPW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int unsigned WCW = $clog2(WQ_DEPTH + 1);
    localparam int unsigned RPW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int unsigned RCW = $clog2(RQ_DEPTH + 1);
    localparam int unsigned OPW = $clog2(OQ_DEPTH);
    localparam int unsigned OCW = $clog2(OQ_DEPTH + 1);
    localparam logic [MW:0] MATS_L = MATS[MW:0];
    localparam logic [CW:0] NCH_L  = NCH[CW:0];

    // Storage and written-row bitmap
    logic [ROW_W-1:0] mem_q    [MATS][ROWS];
    logic [ROWS-1:0]  wr_map_q [MATS];
    logic [ROWS-1:0]  wr_map_d [MATS];

    // Write queue
    logic [MW-1:0]       wq_mat_q  [WQ_DEPTH];
    logic [RW-1:0]       wq_row_q  [WQ_DEPTH];
    logic [ROW_W-1:0]    wq_data_q [WQ_DEPTH];
    logic [WQ_DEPTH-1:0] wq_gemm_q, wq_vld_q;
    logic [WPW-1:0]      wq_head_q, wq_tail_q;
    logic [WCW-1:0]      wq_cnt_q;

    // Read queue
    logic [MW-1:0]    rq_mat_q  [RQ_DEPTH];
    logic [RW-1:0]    rq_row_q  [RQ_DEPTH];
    logic [CW-1:0]    rq_dest_q [RQ_DEPTH];
    logic [TAG_W-1:0] rq_tag_q  [RQ_DEPTH];
    logic [RPW-1:0]   rq_head_q, rq_tail_q;
    logic [RCW-1:0]   rq_cnt_q;

    // Output FIFOs
    logic [MW-1:0]    oq_mat_q  [NCH][OQ_DEPTH];
    logic [RW-1:0]    oq_row_q  [NCH][OQ_DEPTH];
    logic [TAG_W-1:0] oq_tag_q  [NCH][OQ_DEPTH];
    logic [ROW_W-1:0] oq_data_q [NCH][OQ_DEPTH];
    logic [OPW-1:0]   oq_head_q [NCH];
    logic [OPW-1:0]   oq_tail_q [NCH];
    logic [OCW-1:0]   oq_cnt_q  [NCH];
    logic [NCH-1:0]   oq_push, oq_pop;

    logic w_push, w_pop, w_legal, w_commit, w_done;
    logic r_push, r_avail, r_legal, r_pop, r_service, hazard, r_space;
    logic [MW-1:0]    wh_mat, rh_mat;
    logic [RW-1:0]    wh_row, rh_row;
    logic [ROW_W-1:0] wh_data, rd_data;
    logic             wh_gemm;
    logic [CW-1:0]    rh_dest;
    logic [TAG_W-1:0] rh_tag;

    function automatic logic [WPW-1:0] wq_inc(input logic [WPW-1:0] p);
        return (p == WPW'(WQ_DEPTH - 1)) ? '0 : p + WPW'(1);
    endfunction

    function automatic logic [RPW-1:0] rq_inc(input logic [RPW-1:0] p);
        return (p == RPW'(RQ_DEPTH - 1)) ? '0 : p + RPW'(1);
    endfunction

    function automatic logic [OPW-1:0] oq_inc(input logic [OPW-1:0] p);
        return (p == OPW'(OQ_DEPTH - 1)) ? '0 : p + OPW'(1);
    endfunction

    // Ready reflects registered counts only
    assign w_ready  = (wq_cnt_q != WCW'(WQ_DEPTH));
    assign r_ready  = (rq_cnt_q != RCW'(RQ_DEPTH));
    assign w_push   = w_valid && w_ready;
    assign r_push   = r_valid && r_ready;

    assign wh_mat   = wq_mat_q[wq_head_q];
    assign wh_row   = wq_row_q[wq_head_q];
    assign wh_data  = wq_data_q[wq_head_q];
    assign wh_gemm  = wq_gemm_q[wq_head_q];
    assign w_pop    = (wq_cnt_q != '0);
    assign w_legal  = ({1'b0, wh_mat} < MATS_L);
    assign w_commit = w_pop && w_legal;
    assign w_done   = w_commit && (wh_row == RW'(ROWS - 1));

    assign load_complete = w_done && !wh_gemm;
    assign gemm_complete = w_done && wh_gemm;
    assign complete_mat  = w_done ? wh_mat : '0;

    assign rh_mat    = rq_mat_q[rq_head_q];
    assign rh_row    = rq_row_q[rq_head_q];
    assign rh_dest   = rq_dest_q[rq_head_q];
    assign rh_tag    = rq_tag_q[rq_head_q];
    assign r_avail   = (rq_cnt_q != '0);
    assign r_legal   = ({1'b0, rh_mat} < MATS_L) && ({1'b0, rh_dest} < NCH_L);
    assign r_service = r_avail && r_legal && !hazard && r_space;
    // Illegal heads drain immediately; legal heads wait for hazard and space
    assign r_pop     = r_avail && (!r_legal || (!hazard && r_space));
    assign rd_data   = mem_q[rh_mat][rh_row];

    // Illegal read and write in one cycle still give a single err pulse
    assign err = (w_pop && !w_legal) || (r_avail && !r_legal);

    // Read-after-write hazard against every queued write, including the committing head
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (wq_vld_q[i] && (wq_mat_q[i] == rh_mat) && (wq_row_q[i] == rh_row)) begin
                hazard = 1'b1;
            end
        end
    end

    // Destination space, counting a same-cycle pop of a full FIFO as room
    always_comb begin
        r_space = 1'b0;
        oq_push = '0;
        oq_pop  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            oq_pop[ch] = o_ren[ch] && (oq_cnt_q[ch] != '0);
            if (rh_dest == CW'(ch)) begin
                r_space = (oq_cnt_q[ch] != OCW'(OQ_DEPTH)) || o_ren[ch];
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            oq_push[ch] = r_service && (rh_dest == CW'(ch));
        end
    end

    // Bitmap next state: clear first, then the commit sets its own bit
    always_comb begin
        for (int m = 0; m < MATS; m++) begin
            wr_map_d[m] = mat_clear[m] ? '0 : wr_map_q[m];
        end
        if (w_commit) begin
            wr_map_d[wh_mat][wh_row] = 1'b1;
        end
        for (int m = 0; m < MATS; m++) begin
            mat_full[m] = &wr_map_q[m];
        end
    end

    // Array and bitmap update
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int m = 0; m < MATS; m++) begin
                wr_map_q[m] <= '0;
                for (int r = 0; r < ROWS; r++) mem_q[m][r] <= '0;
            end
        end else begin
            for (int m = 0; m < MATS; m++) wr_map_q[m] <= wr_map_d[m];
            if (w_commit) mem_q[wh_mat][wh_row] <= wh_data;
        end
    end

    // Write queue: push at tail, head pops every cycle it is present
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wq_head_q <= '0;
            wq_tail_q <= '0;
            wq_cnt_q  <= '0;
            wq_vld_q  <= '0;
            wq_gemm_q <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) begin
                wq_mat_q[i]  <= '0;
                wq_row_q[i]  <= '0;
                wq_data_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                wq_vld_q[wq_tail_q]  <= 1'b1;
                wq_mat_q[wq_tail_q]  <= w_mat;
                wq_row_q[wq_tail_q]  <= w_row;
                wq_data_q[wq_tail_q] <= w_data;
                wq_gemm_q[wq_tail_q] <= w_gemm;
                wq_tail_q            <= wq_inc(wq_tail_q);
            end
            if (w_pop) begin
                wq_vld_q[wq_head_q] <= 1'b0;
                wq_head_q           <= wq_inc(wq_head_q);
            end
            wq_cnt_q <= wq_cnt_q + WCW'(w_push) - WCW'(w_pop);
        end
    end

    // Read queue: strictly in order, head blocks everything behind it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rq_head_q <= '0;
            rq_tail_q <= '0;
            rq_cnt_q  <= '0;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                rq_mat_q[i]  <= '0;
                rq_row_q[i]  <= '0;
                rq_dest_q[i] <= '0;
                rq_tag_q[i]  <= '0;
            end
        end else begin
            if (r_push) begin
                rq_mat_q[rq_tail_q]  <= r_mat;
                rq_row_q[rq_tail_q]  <= r_row;
                rq_dest_q[rq_tail_q] <= r_dest;
                rq_tag_q[rq_tail_q]  <= r_tag;
                rq_tail_q            <= rq_inc(rq_tail_q);
            end
            if (r_pop) rq_head_q <= rq_inc(rq_head_q);
            rq_cnt_q <= rq_cnt_q + RCW'(r_push) - RCW'(r_pop);
        end
    end

    // Per-channel output FIFOs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int ch = 0; ch < NCH; ch++) begin
                oq_head_q[ch] <= '0;
                oq_tail_q[ch] <= '0;
                oq_cnt_q[ch]  <= '0;
                for (int s = 0; s < OQ_DEPTH; s++) begin
                    oq_mat_q[ch][s]  <= '0;
                    oq_row_q[ch][s]  <= '0;
                    oq_tag_q[ch][s]  <= '0;
                    oq_data_q[ch][s] <= '0;
                end
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (oq_push[ch]) begin
                    oq_mat_q[ch][oq_tail_q[ch]]  <= rh_mat;
                    oq_row_q[ch][oq_tail_q[ch]]  <= rh_row;
                    oq_tag_q[ch][oq_tail_q[ch]]  <= rh_tag;
                    oq_data_q[ch][oq_tail_q[ch]] <= rd_data;
                    oq_tail_q[ch]                <= oq_inc(oq_tail_q[ch]);
                end
                if (oq_pop[ch]) oq_head_q[ch] <= oq_inc(oq_head_q[ch]);
                oq_cnt_q[ch] <= oq_cnt_q[ch] + OCW'(oq_push[ch]) - OCW'(oq_pop[ch]);
            end
        end
    end

    // Head entry per channel, zero when the FIFO is empty
    always_comb begin
        o_valid = '0;
        o_mat   = '0;
        o_row   = '0;
        o_tag   = '0;
        o_data  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (oq_cnt_q[ch] != '0) begin
                o_valid[ch]               = 1'b1;
                o_mat[ch*MW +: MW]        = oq_mat_q[ch][oq_head_q[ch]];
                o_row[ch*RW +: RW]        = oq_row_q[ch][oq_head_q[ch]];
                o_tag[ch*TAG_W +: TAG_W]  = oq_tag_q[ch][oq_head_q[ch]];
                o_data[ch*ROW_W +: ROW_W] = oq_data_q[ch][oq_head_q[ch]];
            end
        end
    end

endmodule

// File: tb/tb_scratchpad_bank_param.sv
// Directed self-checking bench for scratchpad_bank_param: default build plus an
// NCH=3 / MATS=3 build for illegal-request handling.
module tb_scratchpad_bank_param;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    // Default build (MATS=4 ROWS=4 ROW_W=64 TAG_W=32 NCH=2)
    logic        w_valid, w_ready, w_gemm, r_valid, r_ready;
    logic [1:0]  w_mat, w_row, r_mat, r_row, complete_mat, o_valid, o_ren;
    logic [63:0] w_data, o_tag;
    logic [0:0]  r_dest;
    logic [31:0] r_tag;
    logic [3:0]  o_mat, o_row, mat_clear, mat_full;
    logic [127:0] o_data;
    logic        load_complete, gemm_complete, err;

    // Second build (MATS=3 NCH=3 ROW_W=16 TAG_W=8)
    logic        w_valid3, w_ready3, w_gemm3, r_valid3, r_ready3;
    logic [1:0]  w_mat3, w_row3, r_mat3, r_row3, r_dest3, complete_mat3;
    logic [15:0] w_data3;
    logic [7:0]  r_tag3;
    logic [2:0]  o_valid3, o_ren3, mat_clear3, mat_full3;
    logic [5:0]  o_mat3, o_row3;
    logic [23:0] o_tag3;
    logic [47:0] o_data3;
    logic        load_complete3, gemm_complete3, err3;

    int checks = 0;
    int errors = 0;
    int lc_n = 0, gc_n = 0, err_n = 0, err3_n = 0, done3_n = 0;
    logic [1:0] last_cmat = '0;

    scratchpad_bank_param u_dut (
        .CLK(CLK), .nRST(nRST),
        .w_valid(w_valid), .w_ready(w_ready), .w_mat(w_mat), .w_row(w_row),
        .w_data(w_data), .w_gemm(w_gemm),
        .r_valid(r_valid), .r_ready(r_ready), .r_mat(r_mat), .r_row(r_row),
        .r_dest(r_dest), .r_tag(r_tag),
        .o_valid(o_valid), .o_ren(o_ren), .o_mat(o_mat), .o_row(o_row),
        .o_tag(o_tag), .o_data(o_data),
        .mat_clear(mat_clear), .mat_full(mat_full),
        .load_complete(load_complete), .gemm_complete(gemm_complete),
        .complete_mat(complete_mat), .err(err)
    );

    scratchpad_bank_param #(
        .MATS(3), .ROWS(4), .ROW_W(16), .TAG_W(8), .NCH(3),
        .WQ_DEPTH(2), .RQ_DEPTH(2), .OQ_DEPTH(8)
    ) u_dut3 (
        .CLK(CLK), .nRST(nRST),
        .w_valid(w_valid3), .w_ready(w_ready3), .w_mat(w_mat3), .w_row(w_row3),
        .w_data(w_data3), .w_gemm(w_gemm3),
        .r_valid(r_valid3), .r_ready(r_ready3), .r_mat(r_mat3), .r_row(r_row3),
        .r_dest(r_dest3), .r_tag(r_tag3),
        .o_valid(o_valid3), .o_ren(o_ren3), .o_mat(o_mat3), .o_row(o_row3),
        .o_tag(o_tag3), .o_data(o_data3),
        .mat_clear(mat_clear3), .mat_full(mat_full3),
        .load_complete(load_complete3), .gemm_complete(gemm_complete3),
        .complete_mat(complete_mat3), .err(err3)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Advance one clock and sample pulse outputs just after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
        if (load_complete) lc_n++;
        if (gemm_complete) gc_n++;
        if (load_complete || gemm_complete) last_cmat = complete_mat;
        if (err) err_n++;
        if (err3) err3_n++;
        if (load_complete3 || gemm_complete3) done3_n++;
    endtask

    initial begin
        int gc0, lc0;
        nRST = 1'b0;
        {w_valid, w_gemm, r_valid, w_mat, w_row, r_mat, r_row, o_ren} = '0;
        w_data = '0; r_dest = '0; r_tag = '0; mat_clear = '0;
        {w_valid3, w_gemm3, r_valid3, w_mat3, w_row3, r_mat3, r_row3, r_dest3} = '0;
        w_data3 = '0; r_tag3 = '0; o_ren3 = '0; mat_clear3 = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_w_ready", 64'(w_ready), 64'd1);
        check("rst_r_ready", 64'(r_ready), 64'd1);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", o_data[63:0], 64'd0);
        check("rst_mat_full", 64'(mat_full), 64'd0);
        check("rst_pulses", 64'({load_complete, gemm_complete, err, complete_mat}), 64'd0);
        nRST = 1'b1;
        tick();

        // Load mat1 rows 0..3
        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1; w_mat = 2'd1; w_row = 2'(i); w_gemm = 1'b0;
            w_data = 64'(8'h11 * (i + 1));
            tick();
        end
        w_valid = 1'b0;
        repeat (3) tick();
        check("load_pulse_count", 64'(lc_n), 64'd1);
        check("load_gemm_count", 64'(gc_n), 64'd0);
        check("load_complete_mat", 64'(last_cmat), 64'd1);
        check("load_mat_full", 64'(mat_full), 64'b0010);

        // Plain read mat1 row2 to channel 0
        r_valid = 1'b1; r_mat = 2'd1; r_row = 2'd2; r_dest = 1'b0; r_tag = 32'h8000_0040;
        tick();
        r_valid = 1'b0;
        check("rd_not_yet", 64'(o_valid), 64'b00);
        tick();
        check("rd_valid", 64'(o_valid), 64'b01);
        check("rd_data", o_data[63:0], 64'h33);
        check("rd_tag", o_tag[31:0], 64'h8000_0040);
        check("rd_mat_row", 64'({o_mat[1:0], o_row[1:0]}), 64'b0110);
        o_ren = 2'b01;
        tick();
        o_ren = 2'b00;
        check("rd_popped", 64'(o_valid), 64'b00);

        // Write and read of the same row accepted together: read must wait for commit
        w_valid = 1'b1; w_mat = 2'd2; w_row = 2'd0; w_data = 64'hAA; w_gemm = 1'b0;
        r_valid = 1'b1; r_mat = 2'd2; r_row = 2'd0; r_dest = 1'b1; r_tag = 32'd5;
        tick();
        w_valid = 1'b0; r_valid = 1'b0;
        tick();
        check("raw_stalled", 64'(o_valid), 64'b00);
        tick();
        check("raw_valid", 64'(o_valid), 64'b10);
        check("raw_data", o_data[127:64], 64'hAA);
        check("raw_tag", o_tag[63:32], 64'd5);
        o_ren = 2'b10;
        tick();
        o_ren = 2'b00;

        // Fill channel 1 (8 entries) plus two queued reads
        for (int i = 0; i < 10; i++) begin
            r_valid = 1'b1; r_mat = 2'd1; r_row = 2'd0; r_dest = 1'b1; r_tag = 32'(i);
            tick();
        end
        r_valid = 1'b0;
        check("full_r_ready", 64'(r_ready), 64'd0);
        check("full_head_tag", o_tag[63:32], 64'd0);
        check("full_head_data", o_data[127:64], 64'h11);
        repeat (2) tick();
        check("full_still_blocked", 64'(r_ready), 64'd0);
        o_ren = 2'b10;
        tick();
        o_ren = 2'b00;
        check("one_pop_r_ready", 64'(r_ready), 64'd1);
        check("one_pop_head", o_tag[63:32], 64'd1);
        tick();
        check("one_pop_hold_ready", 64'(r_ready), 64'd1);
        check("one_pop_hold_head", o_tag[63:32], 64'd1);
        o_ren = 2'b10;
        for (int k = 1; k < 10; k++) begin
            check("drain_valid", 64'(o_valid[1]), 64'd1);
            check("drain_tag", o_tag[63:32], 64'(k));
            tick();
        end
        o_ren = 2'b00;
        check("drain_empty", 64'(o_valid), 64'b00);

        // Clear mat1 in the same cycle as a GEMM commit to mat1 row3
        gc0 = gc_n; lc0 = lc_n;
        w_valid = 1'b1; w_mat = 2'd1; w_row = 2'd3; w_data = 64'h99; w_gemm = 1'b1;
        tick();
        w_valid = 1'b0; w_gemm = 1'b0; mat_clear = 4'b0010;
        tick();
        mat_clear = 4'b0000;
        check("clr_gemm_pulse", 64'(gc_n - gc0), 64'd1);
        check("clr_no_load_pulse", 64'(lc_n - lc0), 64'd0);
        check("clr_complete_mat", 64'(last_cmat), 64'd1);
        check("clr_mat_full", 64'(mat_full), 64'b0000);
        for (int i = 0; i < 2; i++) begin
            w_valid = 1'b1; w_mat = 2'd1; w_row = 2'(i); w_data = 64'h5;
            tick();
        end
        w_valid = 1'b0;
        repeat (2) tick();
        check("clr_partial", 64'(mat_full), 64'b0000);
        w_valid = 1'b1; w_row = 2'd2;
        tick();
        w_valid = 1'b0;
        repeat (2) tick();
        check("clr_row3_kept", 64'(mat_full), 64'b0010);

        // Illegal destination on the NCH=3 build, then a legal read
        r_valid3 = 1'b1; r_mat3 = 2'd0; r_row3 = 2'd0; r_dest3 = 2'd3; r_tag3 = 8'h11;
        tick();
        r_mat3 = 2'd0; r_row3 = 2'd1; r_dest3 = 2'd2; r_tag3 = 8'h77;
        tick();
        r_valid3 = 1'b0;
        tick();
        check("ill_dest_err", 64'(err3_n), 64'd1);
        check("ill_dest_valid", 64'(o_valid3), 64'b100);
        check("ill_dest_tag", 64'(o_tag3[23:16]), 64'h77);
        check("ill_dest_row", 64'(o_row3[5:4]), 64'd1);

        // Illegal mat write: err, no completion
        w_valid3 = 1'b1; w_mat3 = 2'd3; w_row3 = 2'd3; w_data3 = 16'hBEEF;
        tick();
        w_valid3 = 1'b0;
        tick();
        check("ill_wr_err", 64'(err3_n), 64'd2);
        check("ill_wr_no_done", 64'(done3_n), 64'd0);
        check("ill_wr_full", 64'(mat_full3), 64'd0);

        // Simultaneous illegal write and read: one err pulse
        w_valid3 = 1'b1; w_mat3 = 2'd3; w_row3 = 2'd0;
        r_valid3 = 1'b1; r_mat3 = 2'd0; r_dest3 = 2'd3;
        tick();
        w_valid3 = 1'b0; r_valid3 = 1'b0;
        repeat (2) tick();
        check("ill_both_err", 64'(err3_n), 64'd3);
        check("ill_both_no_push", 64'(o_valid3), 64'b100);
        check("main_no_err", 64'(err_n), 64'd0);

        // Reset mid-operation discards in-flight work
        r_valid = 1'b1; r_mat = 2'd1; r_row = 2'd3; r_dest = 1'b0; r_tag = 32'h1;
        tick();
        r_valid = 1'b0;
        w_valid = 1'b1; w_mat = 2'd0; w_row = 2'd3; w_gemm = 1'b1; w_data = 64'h7;
        tick();
        check("pre_rst_valid", 64'(o_valid), 64'b01);
        check("pre_rst_data", o_data[63:0], 64'h99);
        gc0 = gc_n;
        nRST = 1'b0;
        #1;
        check("mid_rst_o_valid", 64'(o_valid), 64'b00);
        check("mid_rst_o_data", o_data[63:0], 64'd0);
        check("mid_rst_mat_full", 64'(mat_full), 64'd0);
        check("mid_rst_pulse", 64'({gemm_complete, complete_mat}), 64'd0);
        w_valid = 1'b0; w_gemm = 1'b0;
        tick();
        nRST = 1'b1;
        repeat (2) tick();
        check("post_rst_no_commit", 64'(gc_n - gc0), 64'd0);
        check("post_rst_mat_full", 64'(mat_full), 64'd0);
        check("post_rst_ready", 64'({w_ready, r_ready, o_valid}), 64'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
